// File: rtl/full_adder_s_pkg.sv
// Constants shared by the full adder cell and its sub-blocks.
package full_adder_s_pkg;
  localparam logic RST_VAL_DEF = 1'b0;
endpackage

// File: rtl/full_adder_s_half_adder.sv
// Half adder leaf: sum = a^b, carry = a&b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/full_adder_s.sv
// Single-bit full adder with combinational outputs, a registered copy,
// and a bit-serial mode where an internal carry register replaces z.
module full_adder_s
  import full_adder_s_pkg::*;
#(
  parameter logic RST_VAL = RST_VAL_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  input  logic z,
  input  logic ser_en,
  input  logic ser_clr,
  output logic s,
  output logic c,
  output logic s_q,
  output logic c_q
);
  logic cy_q;
  logic cin;
  logic p, g0, g1;

  assign cin = ser_en ? cy_q : z;

  half_adder u_ha0 (.a(x), .b(y),   .sum(p), .carry(g0));
  half_adder u_ha1 (.a(p), .b(cin), .sum(s), .carry(g1));

  assign c = g0 | g1;

  // ser_clr wins over ser_en so a word boundary always starts from zero carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q  <= RST_VAL;
      c_q  <= RST_VAL;
      cy_q <= RST_VAL;
    end else begin
      s_q <= s;
      c_q <= c;
      if (ser_clr)     cy_q <= 1'b0;
      else if (ser_en) cy_q <= c;
    end
  end
endmodule

// File: tb/tb_full_adder_s.sv
// Directed self-checking bench for full_adder_s.
module tb_full_adder_s;
  logic clk, rst, x, y, z, ser_en, ser_clr;
  logic s, c, s_q, c_q;
  int n_cmp, n_err;

  full_adder_s dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z),
    .ser_en(ser_en), .ser_clr(ser_clr),
    .s(s), .c(c), .s_q(s_q), .c_q(c_q)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // one rising edge, inputs held, sampling happens mid-low phase afterwards
  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
    #1;
  endtask

  logic [1:0] tt [8];
  logic [3:0] xb, yb, sb, cb;

  initial begin
    n_cmp = 0; n_err = 0;
    tt[0] = 2'b00; tt[1] = 2'b10; tt[2] = 2'b10; tt[3] = 2'b01;
    tt[4] = 2'b10; tt[5] = 2'b01; tt[6] = 2'b01; tt[7] = 2'b11;
    clk = 0; rst = 0; x = 0; y = 0; z = 0; ser_en = 0; ser_clr = 0;

    // exhaustive combinational, clk idle, rst low
    for (int i = 0; i < 8; i++) begin
      {x, y, z} = 3'(i);
      #10;
      chk($sformatf("comb_s_%0d", i), s, tt[i][1]);
      chk($sformatf("comb_c_%0d", i), c, tt[i][0]);
    end

    // reset held: comb path unaffected, registers at 0
    #1 rst = 1;
    for (int i = 0; i < 8; i++) begin
      {x, y, z} = 3'(i);
      #10;
      chk($sformatf("rst_s_%0d", i), s, tt[i][1]);
      chk($sformatf("rst_c_%0d", i), c, tt[i][0]);
      chk($sformatf("rst_sq_%0d", i), s_q, 1'b0);
      chk($sformatf("rst_cq_%0d", i), c_q, 1'b0);
    end
    // carry register reset: with x=y=0 in serial mode s shows cy_q
    x = 0; y = 0; z = 1; ser_en = 1; #2;
    chk("rst_cy", s, 1'b0);
    ser_en = 0;
    #3 rst = 0;

    // registered latency
    x = 1; y = 1; z = 1; #2;
    chk("lat_sq_pre", s_q, 1'b0);
    chk("lat_cq_pre", c_q, 1'b0);
    tick();
    chk("lat_sq_111", s_q, 1'b1);
    chk("lat_cq_111", c_q, 1'b1);
    x = 0; y = 0; z = 0; #2;
    chk("lat_sq_hold", s_q, 1'b1);
    tick();
    chk("lat_sq_000", s_q, 1'b0);
    chk("lat_cq_000", c_q, 1'b0);

    // bit-serial 5 + 7 = 12, LSB first
    xb = 4'b0101; yb = 4'b0111; sb = 4'b1100; cb = 4'b0111;
    ser_clr = 1; tick(); ser_clr = 0;
    ser_en = 1; z = 1;  // z must be ignored in serial mode
    for (int i = 0; i < 4; i++) begin
      x = xb[i]; y = yb[i]; #1;
      chk($sformatf("ser_s_%0d", i), s, sb[i]);
      chk($sformatf("ser_c_%0d", i), c, cb[i]);
      tick();
    end
    chk("ser_sq_last", s_q, 1'b1);
    chk("ser_cq_last", c_q, 1'b0);
    x = 0; y = 0; #1;
    chk("ser_cy_final", s, 1'b0);

    // async reset mid-word
    x = 1; y = 1; tick();           // cy_q <= 1, s_q=0, c_q=1
    chk("mid_cq", c_q, 1'b1);
    chk("mid_s_cy1", s, 1'b1);      // 1+1+1
    #2 rst = 1; #1;
    chk("arst_sq", s_q, 1'b0);
    chk("arst_cq", c_q, 1'b0);
    chk("arst_s", s, 1'b0);         // cin now 0
    chk("arst_c", c, 1'b1);
    #2 rst = 0; #1;

    // build cy_q=1, then check ser_en toggling swaps cin source at once
    x = 1; y = 1; tick();
    ser_en = 0; z = 0; #1;
    chk("tog_s_z0", s, 1'b0);
    ser_en = 1; #1;
    chk("tog_s_cy", s, 1'b1);

    // ser_clr priority: clear wins, capture still uses old carry
    ser_clr = 1; #1;
    tick();
    ser_clr = 0;
    chk("clr_sq", s_q, 1'b1);
    chk("clr_cq", c_q, 1'b1);
    chk("clr_s_after", s, 1'b0);
    chk("clr_c_after", c, 1'b1);
    x = 0; y = 0; #1;
    chk("clr_cy", s, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
